// File: rtl/inst_refill_axi_bridge_pkg.sv
// inst_refill_axi_bridge_pkg: shared AXI encodings and FSM state type for the refill bridge
package inst_refill_axi_bridge_pkg;
  typedef enum logic [1:0] {IDLE, AR, RD, DRAIN} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/inst_refill_axi_bridge_if.sv
// inst_refill_axi_bridge_if: AXI4 read-address and read-data channels
interface inst_refill_axi_bridge_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_refill_axi_bridge.sv
// inst_refill_axi_bridge: turns icache refill requests into AXI4 INCR line or single-beat reads
module inst_refill_axi_bridge
  import inst_refill_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int LINE_OFF_W = 5,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input logic clk,
  input logic rst,
  input logic flush,
  input logic cache_ena,
  input logic [31:0] c_araddr,
  input logic c_arvalid,
  output logic c_arready,
  output logic [31:0] c_rdata,
  output logic c_rvalid,
  output logic c_rlast,
  input logic c_rready,
  inst_refill_axi_bridge_if.master axi,
  output logic busy,
  output logic bus_err
);
  state_t state, state_nx;
  logic [31:0] addr_q;
  logic [7:0] len_q;
  logic flush_seen;
  logic [3:0] beat_cnt;
  logic beat;
  logic take;
  logic unused_rid;
  assign unused_rid = ^axi.rid;
  assign take = state == IDLE && c_arvalid && !flush;
  assign busy = state != IDLE;
  assign axi.arid = AXI_ID;
  assign axi.araddr = addr_q;
  assign axi.arlen = len_q;
  assign axi.arsize = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;
  // rlast must coincide exactly with the arlen-th beat; any disagreement or bad response is an error
  assign bus_err = beat && (axi.rresp != AXI_RESP_OKAY || (axi.rlast != ({4'b0, beat_cnt} == len_q)));
  // next state and handshake steering; the R path is a pure pass-through while forwarding
  always_comb begin
    state_nx = state;
    c_arready = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    c_rvalid = 1'b0;
    c_rlast = 1'b0;
    c_rdata = '0;
    beat = 1'b0;
    case (state)
      IDLE: state_nx = take ? AR : IDLE;
      AR: begin
        axi.arvalid = 1'b1;
        c_arready = axi.arready;
        state_nx = !axi.arready ? AR : (flush || flush_seen) ? DRAIN : RD;
      end
      RD: begin
        axi.rready = c_rready;
        c_rvalid = axi.rvalid;
        c_rlast = axi.rlast;
        c_rdata = axi.rdata;
        beat = axi.rvalid && c_rready;
        state_nx = (beat && axi.rlast) ? IDLE : flush ? DRAIN : RD;
      end
      DRAIN: begin
        axi.rready = 1'b1;
        beat = axi.rvalid;
        state_nx = (beat && axi.rlast) ? IDLE : DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // capture request payload so AR stays stable while waiting for arready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      len_q <= '0;
    end else if (take) begin
      addr_q <= cache_ena ? {c_araddr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : c_araddr;
      len_q <= cache_ena ? 8'(LINE_WORDS - 1) : 8'd0;
    end
  end
  // remember a flush seen while AR is pending; arvalid cannot be withdrawn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_seen <= 1'b0;
    else flush_seen <= state == AR && !axi.arready && (flush || flush_seen);
  end
  // count accepted beats of the current burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt <= '0;
    else if (beat) beat_cnt <= axi.rlast ? 4'd0 : beat_cnt + 4'd1;
    else if (state == IDLE) beat_cnt <= '0;
  end
endmodule

// File: tb/tb_inst_refill_axi_bridge.sv
// tb_inst_refill_axi_bridge: random-timing AXI memory model with scoreboarded beats and AR payloads
module tb_inst_refill_axi_bridge;
  typedef struct {logic [31:0] data; logic last;} beat_t;
  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  logic clk = 0, rst = 1, flush = 0, cache_ena = 0, c_arvalid = 0, c_rready = 0;
  logic [31:0] c_araddr = 0;
  logic c_arready, c_rvalid, c_rlast, busy, bus_err;
  logic [31:0] c_rdata;
  int errors = 0, checks = 0;
  beat_t exp_beats[$];
  ar_t exp_ar[$];
  int k_ar_delay = 0, k_err_beat = -1, k_last_off = 0;
  int m_phase, m_wait, m_idx, m_last, m_sent;
  logic [31:0] m_addr;
  int fwd_cnt = 0, berr_cnt = 0, ca_cnt = 0;
  logic prev_wait = 0;
  logic [31:0] prev_addr;
  logic [7:0] prev_len;

  inst_refill_axi_bridge_if axi();

  inst_refill_axi_bridge dut (
    .clk(clk), .rst(rst), .flush(flush), .cache_ena(cache_ena), .c_araddr(c_araddr),
    .c_arvalid(c_arvalid), .c_arready(c_arready), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .c_rlast(c_rlast), .c_rready(c_rready), .axi(axi), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI slave: arready after k_ar_delay waiting cycles, beats carry their own address, random gaps
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      axi.arready <= 0; axi.rvalid <= 0; axi.rlast <= 0; axi.rresp <= 0; axi.rdata <= 0; axi.rid <= 0;
      m_phase <= 0; m_wait <= 0; m_idx <= 0; m_sent <= 0;
    end else if (m_phase == 0) begin
      if (axi.arvalid && axi.arready) begin
        axi.arready <= 0;
        m_addr <= axi.araddr;
        m_last <= int'(axi.arlen) + k_last_off;
        m_idx <= 0; m_sent <= 0; m_wait <= 0; m_phase <= 1;
      end else if (axi.arvalid) begin
        if (m_wait >= k_ar_delay) axi.arready <= 1;
        else m_wait <= m_wait + 1;
      end
    end else begin
      if (axi.rvalid && axi.rready) begin
        m_sent <= m_sent + 1;
        axi.rvalid <= 0;
        if (axi.rlast) m_phase <= 0;
        else m_idx <= m_idx + 1;
      end else if (!axi.rvalid && $urandom_range(0, 2) != 0) begin
        axi.rvalid <= 1;
        axi.rdata <= m_addr + 32'(4 * m_idx);
        axi.rlast <= m_idx == m_last;
        axi.rresp <= (m_idx == k_err_beat) ? 2'b10 : 2'b00;
      end
    end
  end

  // monitor: compares AR payloads and forwarded beats against queued expectations
  always @(negedge clk) begin : mon
    beat_t b;
    ar_t a;
    if (rst) prev_wait <= 0;
    else begin
      if (prev_wait) check("ar_hold", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, prev_addr, prev_len});
      prev_wait <= axi.arvalid && !axi.arready;
      prev_addr <= axi.araddr;
      prev_len <= axi.arlen;
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got addr %0h, required no request", axi.araddr);
        end else begin
          a = exp_ar.pop_front();
          check("araddr", axi.araddr, a.addr);
          check("arlen", axi.arlen, a.len);
          check("ar_fixed", {axi.arsize, axi.arburst, axi.arid}, {3'd2, 2'd1, 4'd0});
          check("c_arready_on_hs", c_arready, 1);
        end
      end else if (c_arready) check("c_arready_spurious", c_arready, 0);
      if (c_arready) ca_cnt <= ca_cnt + 1;
      if (c_rvalid && c_rready) begin
        fwd_cnt <= fwd_cnt + 1;
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b, required none", c_rdata, c_rlast);
        end else begin
          b = exp_beats.pop_front();
          check("beat", {c_rlast, c_rdata}, {b.last, b.data});
        end
      end
      if (bus_err) berr_cnt <= berr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    c_rready = $urandom_range(0, 3) != 0;
  endtask

  // fmode: 0 none, 1 flush after fafter forwarded beats, 2 flush while AR pending
  task automatic run(input logic [31:0] a, input logic ce, input int ard, input int err_b,
                     input int last_off, input int fmode, input int fafter, input int exp_err);
    logic [31:0] base;
    int len, last_idx, nfwd, ca0, fw0, be0, n;
    base = ce ? a - a % 32 : a;
    len = ce ? 7 : 0;
    last_idx = len + last_off;
    nfwd = fmode == 1 ? fafter : fmode == 2 ? 0 : last_idx + 1;
    k_ar_delay = ard; k_err_beat = err_b; k_last_off = last_off;
    exp_ar.push_back('{base, 8'(len)});
    for (int i = 0; i < nfwd; i++) exp_beats.push_back('{base + 32'(4 * i), i == last_idx});
    ca0 = ca_cnt; fw0 = fwd_cnt; be0 = berr_cnt; n = 0;
    c_araddr = a; cache_ena = ce; c_arvalid = 1;
    if (fmode == 2) begin
      tick(); flush = 1; tick(); flush = 0;
    end
    while (ca_cnt == ca0 && n < 200) begin tick(); n++; end
    c_arvalid = 0; cache_ena = 1'($urandom_range(0, 1)); c_araddr = $urandom;
    if (fmode == 1) begin
      while (fwd_cnt - fw0 < fafter && n < 400) begin tick(); n++; end
      flush = 1; c_rready = 0;
      tick();
      flush = 0;
    end
    while ((busy || m_phase != 0) && n < 600) begin tick(); n++; end
    tick();
    check("idle_in_budget", busy, 0);
    check("beats_left", exp_beats.size(), 0);
    check("ar_left", exp_ar.size(), 0);
    check("c_arready_pulses", ca_cnt - ca0, 1);
    check("bus_err_pulses", berr_cnt - be0, exp_err);
    check("axi_beats_consumed", m_sent, last_idx + 1);
  endtask

  initial begin
    int fw0, n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {axi.arvalid, axi.rready, c_arready, c_rvalid, c_rlast, busy, bus_err, c_rdata}, 0);
    rst = 0;
    tick();
    run(32'hF000_0044, 1, 0, -1, 0, 0, 0, 0);
    run(32'h1FC0_0004, 0, 0, -1, 0, 0, 0, 0);
    run(32'hF000_0100, 1, 4, -1, 0, 0, 0, 0);
    run(32'hF000_0208, 1, 0, -1, 0, 1, 3, 0);
    run(32'hF000_0000, 1, 1, -1, 0, 0, 0, 0);
    run(32'hF000_0300, 1, 3, -1, 0, 2, 0, 0);
    run(32'hF000_0400, 1, 0, 1, 0, 0, 0, 1);
    run(32'hF000_0500, 1, 0, -1, -2, 0, 0, 1);
    run(32'hF000_0600, 1, 0, -1, 1, 0, 0, 2);
    for (int i = 0; i < 20; i++) begin
      logic ce;
      ce = 1'($urandom_range(0, 1));
      run($urandom, ce, $urandom_range(0, 3), -1, 0, (ce && $urandom_range(0, 2) == 0) ? 1 : 0,
          $urandom_range(1, 7), 0);
    end
    k_ar_delay = 0; k_err_beat = -1; k_last_off = 0;
    exp_ar.push_back('{32'hF000_0780, 8'd7});
    for (int i = 0; i < 8; i++) exp_beats.push_back('{32'hF000_0780 + 32'(4 * i), i == 7});
    fw0 = fwd_cnt; n = 0;
    c_araddr = 32'hF000_0788; cache_ena = 1; c_arvalid = 1;
    while (!busy && n < 50) begin tick(); n++; end
    c_arvalid = 0;
    while (fwd_cnt - fw0 < 2 && n < 300) begin tick(); n++; end
    check("reached_rd", busy, 1);
    #2 rst = 1;
    #1 check("async_rst_outputs", {axi.arvalid, axi.rready, c_arready, c_rvalid, c_rlast, busy, bus_err, c_rdata}, 0);
    exp_beats.delete();
    exp_ar.delete();
    @(posedge clk);
    #1 rst = 0;
    tick();
    run(32'hF000_0800, 1, 2, -1, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary, required completion");
    $fatal(1);
  end
endmodule
